hit_timestamper: RTL and testbench

Downstream consumer of the 3-bit fine time counter in the pulse registration system. The block extends the fine count with a CW-bit coarse counter advanced by the fine counter's carry pulse, detects rising edges on NCH synchronous hit lines, and stamps each cycle containing new edges as one word {channel mask, coarse, fine}. Words are buffered in a DEPTH-entry FIFO and drained through a valid/ready interface to the readout logic.

---
 rtl/hit_timestamper.sv | 78 +++++++
 tb/tb_hit_timestamper.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hit_timestamper.sv
// hit_timestamper: extends the fine count with a coarse counter, stamps rising hit edges
// and queues the stamps in a FIFO with a valid/ready drain and drop accounting.
module hit_timestamper #(
  parameter int NCH   = 4,
  parameter int CW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           fine_in,
  input  logic                 carry_in,
  input  logic                 enable,
  input  logic [NCH-1:0]       hit,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH+CW+2:0]    out_data,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = NCH + CW + 3;
  logic [CW-1:0]  coarse_q, coarse_d;
  logic [NCH-1:0] hit_q, hit_d, new_w;
  logic [WW-1:0]  mem_q [DEPTH];
  logic [WW-1:0]  mem_d [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           valid_q, valid_d, overflow_q, overflow_d;
  logic [7:0]     drop_q, drop_d;
  logic           stamp, full, push, pop, drop;
  always_comb begin
    new_w      = hit & ~hit_q;
    stamp      = enable & (|new_w);
    full       = cnt_q == (AW+1)'(DEPTH);
    pop        = valid_q & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push       = stamp & (~full | pop);
    drop       = stamp & full & ~pop;
    coarse_d   = coarse_q + CW'(carry_in);
    hit_d      = hit;
    mem_d      = mem_q;
    if (push) mem_d[wr_q] = {new_w, coarse_q, fine_in};
    wr_d       = wr_q + AW'(push);
    rd_d       = rd_q + AW'(pop);
    cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    valid_d    = cnt_d != '0;
    overflow_d = drop | (overflow_q & ~clear);
    drop_d     = clear ? 8'(drop) : drop_q + 8'(drop && drop_q != 8'hff);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coarse_q   <= '0;
      hit_q      <= '0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      coarse_q   <= coarse_d;
      hit_q      <= hit_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = mem_q[rd_q];
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_hit_timestamper.sv
// tb_hit_timestamper: directed table vectors plus hand sequences, DUT built with CW = 4.
module tb_hit_timestamper;
  logic        clk = 1'b0, rst_n = 1'b0, carry_in = 1'b0, enable = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [2:0]  fine_in = '0;
  logic [3:0]  hit = '0;
  logic        out_valid, overflow;
  logic [10:0] out_data;
  logic [7:0]  drop_cnt;
  int checks = 0, errors = 0;

  hit_timestamper #(.NCH(4), .CW(4), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .fine_in(fine_in), .carry_in(carry_in), .enable(enable),
    .hit(hit), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] h; logic e; logic [2:0] f; logic c; logic r; logic cl;
    logic v; logic [10:0] d; logic o; logic [7:0] dc;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [10:0] w(input logic [3:0] m, input logic [3:0] c, input logic [2:0] f);
    return {m, c, f};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick(input logic [3:0] h, input logic e, input logic [2:0] f,
                      input logic c, input logic r, input logic cl);
    hit = h; enable = e; fine_in = f; carry_in = c; out_ready = r; clear = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic carry();
    tick(4'h0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hit = '0; enable = 1'b0; fine_in = '0; carry_in = 1'b0; out_ready = 1'b0; clear = 1'b0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{4'h0, 1, 3'd0, 0, 0, 0, 0, w(0, 0, 0), 0, 0};
    tbl[1] = '{4'h1, 1, 3'd3, 0, 0, 0, 1, w(1, 0, 3), 0, 0};
    tbl[2] = '{4'h1, 1, 3'd4, 0, 1, 0, 0, w(0, 0, 0), 0, 0};
    tbl[3] = '{4'h0, 1, 3'd7, 1, 1, 0, 0, w(0, 0, 0), 0, 0};
    tbl[4] = '{4'h6, 1, 3'd0, 0, 0, 0, 1, w(6, 1, 0), 0, 0};
    tbl[5] = '{4'h6, 1, 3'd7, 1, 0, 0, 1, w(6, 1, 0), 0, 0};
    tbl[6] = '{4'hf, 0, 3'd0, 0, 0, 0, 1, w(6, 1, 0), 0, 0};
    tbl[7] = '{4'h0, 1, 3'd1, 0, 1, 0, 0, w(0, 0, 0), 0, 0};
    tbl[8] = '{4'hf, 1, 3'd5, 0, 0, 0, 1, w(15, 2, 5), 0, 0};
    tbl[9] = '{4'hf, 1, 3'd6, 0, 1, 0, 0, w(0, 0, 0), 0, 0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].h, tbl[i].e, tbl[i].f, tbl[i].c, tbl[i].r, tbl[i].cl);
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].v);
      if (tbl[i].v) chk($sformatf("vec%0d_data", i), out_data, tbl[i].d);
      chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].o);
      chk($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].dc);
    end

    // idle after reset, then 8 carries
    do_reset();
    tick(4'h0, 1, 3'd0, 0, 0, 0);
    chk("idle_valid", out_valid, 0);
    repeat (8) carry();
    tick(4'h1, 1, 3'd3, 0, 0, 0);
    chk("c8_valid", out_valid, 1);
    chk("c8_data", out_data, w(1, 8, 3));

    // stamp coincident with carry
    do_reset();
    repeat (5) carry();
    tick(4'h1, 1, 3'd7, 1, 0, 0);
    tick(4'h3, 1, 3'd0, 0, 0, 0);
    chk("cc_first", out_data, w(1, 5, 7));
    tick(4'h3, 1, 3'd1, 0, 1, 0);
    chk("cc_second", out_data, w(2, 6, 0));
    chk("cc_second_v", out_valid, 1);
    tick(4'h3, 1, 3'd2, 0, 1, 0);
    chk("cc_empty", out_valid, 0);

    // simultaneous edges on held lines, then disabled edges
    do_reset();
    tick(4'h5, 1, 3'd2, 0, 0, 0);
    repeat (9) tick(4'h5, 1, 3'd4, 0, 0, 0);
    chk("multi_data", out_data, w(5, 0, 2));
    tick(4'h5, 1, 3'd4, 0, 1, 0);
    chk("multi_one", out_valid, 0);
    tick(4'h0, 0, 3'd0, 0, 0, 0);
    tick(4'ha, 0, 3'd0, 0, 0, 0);
    tick(4'h0, 0, 3'd0, 0, 0, 0);
    tick(4'hf, 0, 3'd0, 0, 0, 0);
    chk("dis_none", out_valid, 0);

    // overflow: 10 edges into 8 entries
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick(4'(1 << (k % 4)), 1, 3'(k), 0, 0, 0);
      if (k == 7) chk("full_no_ovf", overflow, 0);
      tick(4'h0, 1, 3'd0, 0, 0, 0);
    end
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt", drop_cnt, 2);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_v", k), out_valid, 1);
      chk($sformatf("drain%0d_d", k), out_data, w(4'(1 << (k % 4)), 0, 3'(k)));
      tick(4'h0, 1, 3'd0, 0, 1, 0);
    end
    chk("drain_empty", out_valid, 0);
    tick(4'h0, 1, 3'd0, 0, 0, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_cnt", drop_cnt, 0);

    // full with simultaneous push and pop
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick(4'(1 << (k % 4)), 1, 3'(k), 0, 0, 0);
      tick(4'h0, 1, 3'd0, 0, 0, 0);
    end
    tick(4'hf, 1, 3'd3, 0, 1, 0);
    chk("pp_ovf", overflow, 0);
    chk("pp_cnt", drop_cnt, 0);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("pp%0d_d", k), out_data, w(4'(1 << (k % 4)), 0, 3'(k)));
      tick(4'hf, 1, 3'd0, 0, 1, 0);
    end
    chk("pp_last_v", out_valid, 1);
    chk("pp_last_d", out_data, w(15, 0, 3));
    tick(4'hf, 1, 3'd0, 0, 1, 0);
    chk("pp_empty", out_valid, 0);

    // drop coinciding with clear
    tick(4'h0, 1, 3'd0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tick(4'h1, 1, 3'(k), 0, 0, 0);
      tick(4'h0, 1, 3'd0, 0, 0, 0);
    end
    tick(4'h1, 1, 3'd0, 0, 0, 0);
    tick(4'h0, 1, 3'd0, 0, 0, 0);
    chk("dc_pre", drop_cnt, 1);
    tick(4'h2, 1, 3'd0, 0, 0, 1);
    chk("dc_ovf", overflow, 1);
    chk("dc_cnt", drop_cnt, 1);
    tick(4'h0, 1, 3'd0, 0, 0, 1);
    chk("dc_clr_ovf", overflow, 0);
    chk("dc_clr_cnt", drop_cnt, 0);

    // coarse wrap at CW = 4
    do_reset();
    repeat (15) carry();
    tick(4'h1, 1, 3'd7, 1, 0, 0);
    tick(4'h0, 1, 3'd0, 0, 0, 0);
    tick(4'h2, 1, 3'd3, 0, 0, 0);
    chk("wrap_pre", out_data, w(1, 15, 7));
    tick(4'h2, 1, 3'd0, 0, 1, 0);
    chk("wrap_post", out_data, w(2, 0, 3));

    // reset with 3 words queued
    tick(4'h7, 1, 3'd1, 0, 0, 0);
    tick(4'h0, 1, 3'd0, 0, 0, 0);
    tick(4'h8, 1, 3'd2, 0, 0, 0);
    chk("q3_valid", out_valid, 1);
    do_reset();
    tick(4'h0, 1, 3'd0, 0, 0, 0);
    chk("post_rst_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
